hyperbus_trans_splitter: RTL and testbench
==========================================

// Module: hyperbus_trans_splitter
// PURPOSE
// Upstream feeder of the HyperBus PHY transaction port. Accepts one linear memory request
// (word address + length in 16-bit words) and splits it into PHY transactions.
// Each transaction is capped by MAX_BURST and never crosses a BOUNDARY_WORDS-aligned boundary.
// Tracks data beats per transaction, propagates PHY errors and returns one completion per request.
// PARAMETERS
// BURST_WIDTH     12    width of trans_burst_o; MAX_BURST <= 2**BURST_WIDTH-1
// NR_CS           2     number of chip selects (one-hot)
// LEN_WIDTH       16    width of req_len_i (words)
// MAX_BURST       256   max words per PHY transaction (>=1)
// BOUNDARY_WORDS  1024  power of two; no transaction crosses a multiple of it
// PORTS
// clk90                  in   1           clock; all logic on posedge clk90
// rst_ni                 in   1           reset, asynchronous, active-low
// req_valid_i            in   1           request valid
// req_ready_o            out  1           request ready
// req_addr_i             in   32          start word address
// req_len_i              in   LEN_WIDTH   length in words (0 allowed)
// req_cs_i               in   NR_CS       chip select, one-hot
// req_write_i            in   1           1 = write, 0 = read
// req_addr_space_i       in   1           1 = register space
// trans_valid_o          out  1           PHY transaction valid
// trans_ready_i          in   1           PHY transaction ready
// trans_address_o        out  32          transaction word address
// trans_cs_o             out  NR_CS       transaction chip select
// trans_write_o          out  1           transaction direction
// trans_burst_o          out  BURST_WIDTH words in this transaction (>=1)
// trans_address_space_o  out  1           register-space flag
// trans_error_i          in   1           PHY error (tCSM timeout) indication
// tx_beat_i              in   1           PHY write beat accepted (tx_valid & tx_ready)
// rx_beat_i              in   1           PHY read beat delivered (rx_valid & rx_ready)
// done_valid_o           out  1           request completion valid
// done_ready_i           in   1           completion ready
// done_error_o           out  1           request had a PHY error; valid with done_valid_o
// BEHAVIOUR
// Reset (async, rst_ni=0): state IDLE.
// - All outputs 0, except req_ready_o=1.
// - Internal addr, remaining, chunk, beat_cnt and err cleared.
// FSM states: IDLE, CALC, ISSUE, DATA, DONE.
// IDLE:
// - req_ready_o=1.
// - On req_valid_i: latch addr, len->remaining, cs, write, addr_space; clear err.
// - Go to DONE if len==0, else CALC.
// CALC (one cycle): chunk = min(remaining, MAX_BURST, BOUNDARY_WORDS - (addr mod BOUNDARY_WORDS)).
// - addr_space=1: chunk=1 and the request ends after this transaction.
// ISSUE:
// - trans_valid_o=1; all trans_* fields are registered and stable while valid.
// - trans_burst_o=chunk[BURST_WIDTH-1:0].
// - On trans_ready_i: beat_cnt=0, go to DATA.
// - Latency: request handshake at edge N -> trans_valid_o high after edge N+2.
// DATA:
// - beat_cnt increments on tx_beat_i when write=1, on rx_beat_i when write=0. The other beat input is ignored.
// - When the counted beat makes beat_cnt==chunk: addr+=chunk (32-bit wrap), remaining-=chunk.
// - Then go to DONE if remaining==0 or addr_space=1, else CALC.
// - Beats seen in IDLE, CALC, ISSUE or DONE are ignored.
// trans_error_i high in ISSUE or DATA:
// - err<=1, trans_valid_o drops next cycle, remaining words are abandoned, go to DONE.
// - Error takes priority over a simultaneous final beat.
// DONE:
// - done_valid_o=1 and done_error_o=err, both held until done_ready_i; then IDLE.
// - req_ready_o=0 in every state except IDLE; one request in flight at most.
// - A new request is accepted no earlier than the edge after the done handshake.
// Width rules:
// - remaining is LEN_WIDTH bits; chunk and beat_cnt are BURST_WIDTH+1 bits.
// - The min() is computed at full width before truncation.
// - BOUNDARY_WORDS - offset is evaluated at 32 bits.
// Mid-operation reset: immediate return to reset values. No completion is issued for an in-flight request.
// TESTING
// Read, addr=0x10, len=8, MAX_BURST=256 -> one trans: addr 0x10, burst 8.
// - 8 rx beats -> done_valid=1, done_error=0.
// Write, addr=0x3F0, len=40, BOUNDARY=1024 -> trans (0x3F0,16) then (0x400,24).
// - Second trans_valid only after 16th tx beat.
// Read, addr=0, len=600, MAX_BURST=256 -> bursts 256, 256, 88 at 0x0, 0x100, 0x200; one done.
// len=0 -> no trans_valid_o; done_valid_o two cycles after accept, done_error=0.
// Write, len=300, trans_error_i pulsed after 10 beats of first burst -> no second trans; done_error=1.
// Register write, addr_space=1, len=5 -> single trans with burst 1.
// - Done after 1 tx beat; also check trans_valid held stable while trans_ready_i=0 for 3 cycles.

Source files
------------

// File: rtl/hyperbus_trans_splitter_if.sv
// Request, PHY transaction and completion signals of the HyperBus transaction splitter.
// The slave modport is the splitter; the master modport is the requester plus PHY side.
interface hyperbus_trans_splitter_if #(
  parameter int unsigned BURST_WIDTH = 12,
  parameter int unsigned NR_CS       = 2,
  parameter int unsigned LEN_WIDTH   = 16
);
  logic                   req_valid;
  logic                   req_ready;
  logic [31:0]            req_addr;
  logic [LEN_WIDTH-1:0]   req_len;
  logic [NR_CS-1:0]       req_cs;
  logic                   req_write;
  logic                   req_addr_space;

  logic                   trans_valid;
  logic                   trans_ready;
  logic [31:0]            trans_address;
  logic [NR_CS-1:0]       trans_cs;
  logic                   trans_write;
  logic [BURST_WIDTH-1:0] trans_burst;
  logic                   trans_address_space;
  logic                   trans_error;
  logic                   tx_beat;
  logic                   rx_beat;

  logic                   done_valid;
  logic                   done_ready;
  logic                   done_error;

  modport slave (
    input  req_valid, req_addr, req_len, req_cs, req_write, req_addr_space,
    output req_ready,
    output trans_valid, trans_address, trans_cs, trans_write, trans_burst, trans_address_space,
    input  trans_ready, trans_error, tx_beat, rx_beat,
    output done_valid, done_error,
    input  done_ready
  );

  modport master (
    output req_valid, req_addr, req_len, req_cs, req_write, req_addr_space,
    input  req_ready,
    input  trans_valid, trans_address, trans_cs, trans_write, trans_burst, trans_address_space,
    output trans_ready, trans_error, tx_beat, rx_beat,
    input  done_valid, done_error,
    output done_ready
  );
endinterface

// File: rtl/hyperbus_trans_splitter.sv
// Splits one linear word request into HyperBus PHY transactions capped by MAX_BURST and
// never crossing a BOUNDARY_WORDS boundary; counts data beats and returns one completion.
module hyperbus_trans_splitter #(
  parameter int unsigned BURST_WIDTH    = 12,
  parameter int unsigned NR_CS          = 2,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned MAX_BURST      = 256,
  parameter int unsigned BOUNDARY_WORDS = 1024
) (
  input logic                      clk90,
  input logic                      rst_ni,
  hyperbus_trans_splitter_if.slave bus_io
);

  typedef enum logic [2:0] {StIdle, StCalc, StIssue, StData, StDone} state_e;

  localparam logic [31:0] MaxBurstW = 32'(MAX_BURST);
  localparam logic [31:0] BoundW    = 32'(BOUNDARY_WORDS);

  state_e                 state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [BURST_WIDTH:0]   chunk_q, chunk_d;
  logic [BURST_WIDTH:0]   beat_cnt_q, beat_cnt_d;
  logic                   err_q, err_d;
  logic [NR_CS-1:0]       cs_q, cs_d;
  logic                   write_q, write_d;
  logic                   space_q, space_d;
  logic                   trans_valid_q, trans_valid_d;
  logic                   done_valid_q, done_valid_d;

  logic [31:0]            rem_w, bnd_w, min_w;
  logic [LEN_WIDTH-1:0]   rem_sub;
  logic [BURST_WIDTH:0]   beat_inc;
  logic                   beat;

  // Chunk size is the min of three limits, evaluated at 32 bits before truncation.
  always_comb begin
    rem_w = 32'(rem_q);
    bnd_w = BoundW - (addr_q & (BoundW - 32'd1));
    min_w = rem_w;
    if (MaxBurstW < min_w) min_w = MaxBurstW;
    if (bnd_w < min_w)     min_w = bnd_w;
  end

  assign rem_sub  = rem_q - LEN_WIDTH'(chunk_q);
  assign beat_inc = beat_cnt_q + (BURST_WIDTH+1)'(1);
  assign beat     = write_q ? bus_io.tx_beat : bus_io.rx_beat;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    chunk_d       = chunk_q;
    beat_cnt_d    = beat_cnt_q;
    err_d         = err_q;
    cs_d          = cs_q;
    write_d       = write_q;
    space_d       = space_q;
    trans_valid_d = 1'b0;
    done_valid_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.req_valid) begin
          addr_d  = bus_io.req_addr;
          rem_d   = bus_io.req_len;
          cs_d    = bus_io.req_cs;
          write_d = bus_io.req_write;
          space_d = bus_io.req_addr_space;
          err_d   = 1'b0;
          state_d = (bus_io.req_len == '0) ? StDone : StCalc;
        end
      end
      StCalc: begin
        chunk_d = space_q ? (BURST_WIDTH+1)'(1) : (BURST_WIDTH+1)'(min_w);
        state_d = StIssue;
      end
      StIssue: begin
        if (bus_io.trans_error) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (trans_valid_q && bus_io.trans_ready) begin
          beat_cnt_d = '0;
          state_d    = StData;
        end else begin
          trans_valid_d = 1'b1;
        end
      end
      StData: begin
        // An error abandons the request even when it coincides with the final beat.
        if (bus_io.trans_error) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (beat) begin
          beat_cnt_d = beat_inc;
          if (beat_inc == chunk_q) begin
            addr_d  = addr_q + 32'(chunk_q);
            rem_d   = rem_sub;
            state_d = (rem_sub == '0 || space_q) ? StDone : StCalc;
          end
        end
      end
      StDone: begin
        if (done_valid_q && bus_io.done_ready) begin
          state_d = StIdle;
        end else begin
          done_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk90 or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      rem_q         <= '0;
      chunk_q       <= '0;
      beat_cnt_q    <= '0;
      err_q         <= 1'b0;
      cs_q          <= '0;
      write_q       <= 1'b0;
      space_q       <= 1'b0;
      trans_valid_q <= 1'b0;
      done_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      chunk_q       <= chunk_d;
      beat_cnt_q    <= beat_cnt_d;
      err_q         <= err_d;
      cs_q          <= cs_d;
      write_q       <= write_d;
      space_q       <= space_d;
      trans_valid_q <= trans_valid_d;
      done_valid_q  <= done_valid_d;
    end
  end

  assign bus_io.req_ready           = (state_q == StIdle);
  assign bus_io.trans_valid         = trans_valid_q;
  assign bus_io.trans_address       = addr_q;
  assign bus_io.trans_cs            = cs_q;
  assign bus_io.trans_write         = write_q;
  assign bus_io.trans_burst         = chunk_q[BURST_WIDTH-1:0];
  assign bus_io.trans_address_space = space_q;
  assign bus_io.done_valid          = done_valid_q;
  assign bus_io.done_error          = done_valid_q & err_q;

endmodule

// File: tb/tb_hyperbus_trans_splitter.sv
// Randomised bench for hyperbus_trans_splitter: a queue-based model derives the expected
// transaction list per request, a PHY responder consumes it and checks timing and fields.
module tb_hyperbus_trans_splitter;

  localparam int unsigned BURST_WIDTH    = 12;
  localparam int unsigned NR_CS          = 2;
  localparam int unsigned LEN_WIDTH      = 16;
  localparam int unsigned MAX_BURST      = 256;
  localparam int unsigned BOUNDARY_WORDS = 1024;

  logic clk90 = 1'b0;
  logic rst_ni = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0]  exp_addr[$];
  int unsigned  exp_burst[$];

  always #5 clk90 = ~clk90;

  hyperbus_trans_splitter_if #(
    .BURST_WIDTH(BURST_WIDTH), .NR_CS(NR_CS), .LEN_WIDTH(LEN_WIDTH)
  ) bus ();

  hyperbus_trans_splitter #(
    .BURST_WIDTH   (BURST_WIDTH),
    .NR_CS         (NR_CS),
    .LEN_WIDTH     (LEN_WIDTH),
    .MAX_BURST     (MAX_BURST),
    .BOUNDARY_WORDS(BOUNDARY_WORDS)
  ) dut (
    .clk90 (clk90),
    .rst_ni(rst_ni),
    .bus_io(bus)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.req_valid = 0; bus.req_addr = '0; bus.req_len = '0; bus.req_cs = '0;
    bus.req_write = 0; bus.req_addr_space = 0; bus.trans_ready = 0; bus.trans_error = 0;
    bus.tx_beat = 0; bus.rx_beat = 0; bus.done_ready = 0;
  endtask

  task automatic hard_reset();
    clear_inputs();
    @(negedge clk90);
    rst_ni = 0;
    repeat (3) @(negedge clk90);
    rst_ni = 1;
    @(negedge clk90);
  endtask

  // Expected transaction list from the splitting rules.
  task automatic build_model(input logic [31:0] addr, input int unsigned len, input logic sp);
    logic [31:0] a;
    int unsigned r, c, room;
    exp_addr.delete();
    exp_burst.delete();
    a = addr;
    r = len;
    while (r > 0) begin
      room = BOUNDARY_WORDS - (a % BOUNDARY_WORDS);
      c = r;
      if (c > MAX_BURST) c = MAX_BURST;
      if (c > room) c = room;
      if (sp) c = 1;
      exp_addr.push_back(a);
      exp_burst.push_back(c);
      a = a + c;
      r = r - c;
      if (sp) break;
    end
  endtask

  // Issues one request, plays the PHY and completion side, checks everything inline.
  // lat: negedges after the request edge until the first trans_valid (or done_valid if none).
  task automatic do_request(input logic [31:0] addr, input int unsigned len, input logic [1:0] cs,
                            input logic wr, input logic sp, input int err_beat,
                            input bit err_with_beat, input int hold, output int lat);
    int ntr, cyc, dhold;
    bit exp_err, seen;
    logic [47:0] want_f, got_f;
    build_model(addr, len, sp);
    ntr = exp_burst.size();
    exp_err = 0;
    if (err_beat >= 0 && ntr > 0) begin
      ntr = 1;
      exp_err = 1;
    end
    lat = -1;
    @(negedge clk90);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_idle got=%b want=1", bus.req_ready);
    end
    bus.req_valid = 1; bus.req_addr = addr; bus.req_len = LEN_WIDTH'(len);
    bus.req_cs = cs; bus.req_write = wr; bus.req_addr_space = sp;
    @(negedge clk90);
    bus.req_valid = 0;
    cyc = 1;
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL req_ready_busy got=%b want=0", bus.req_ready);
    end
    for (int k = 0; k < ntr; k++) begin
      seen = 0;
      for (int w = 0; w < 200; w++) begin
        if (bus.trans_valid === 1'b1) begin seen = 1; break; end
        if (bus.done_valid === 1'b1) break;
        @(negedge clk90);
        cyc++;
      end
      n_checks++;
      if (!seen) begin
        n_fail++;
        $display("FAIL trans_valid_wait k=%0d got done=%b valid=%b want valid=1",
                 k, bus.done_valid, bus.trans_valid);
        hard_reset();
        return;
      end
      if (k == 0) lat = cyc;
      want_f = {exp_addr[k], BURST_WIDTH'(exp_burst[k]), cs, wr, sp};
      got_f  = {bus.trans_address, bus.trans_burst, bus.trans_cs, bus.trans_write,
                bus.trans_address_space};
      n_checks++;
      if (got_f !== want_f) begin
        n_fail++;
        $display("FAIL trans_fields k=%0d got=%h want=%h", k, got_f, want_f);
      end
      for (int h = 0; h < hold; h++) begin
        @(negedge clk90);
        got_f = {bus.trans_address, bus.trans_burst, bus.trans_cs, bus.trans_write,
                 bus.trans_address_space};
        n_checks++;
        if (bus.trans_valid !== 1'b1 || got_f !== want_f) begin
          n_fail++;
          $display("FAIL trans_hold k=%0d got=%b/%h want=1/%h", k, bus.trans_valid, got_f, want_f);
        end
      end
      bus.trans_ready = 1;
      @(negedge clk90);
      bus.trans_ready = 0;
      n_checks++;
      if (bus.trans_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL trans_drop k=%0d got=%b want=0", k, bus.trans_valid);
      end
      for (int b = 0; b < int'(exp_burst[k]); b++) begin
        if (exp_err && b == err_beat) begin
          bus.trans_error = 1;
          if (err_with_beat) begin
            if (wr) bus.tx_beat = 1; else bus.rx_beat = 1;
          end
          @(negedge clk90);
          bus.trans_error = 0; bus.tx_beat = 0; bus.rx_beat = 0;
          break;
        end
        // Opposite-direction beat must not be counted.
        if ($urandom_range(0, 3) == 0) begin
          if (wr) bus.rx_beat = 1; else bus.tx_beat = 1;
          @(negedge clk90);
          bus.tx_beat = 0; bus.rx_beat = 0;
        end
        n_checks++;
        if (bus.trans_valid !== 1'b0 || bus.done_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL data_quiet k=%0d beat=%0d got valid=%b done=%b want 0/0",
                   k, b, bus.trans_valid, bus.done_valid);
        end
        if (wr) bus.tx_beat = 1; else bus.rx_beat = 1;
        @(negedge clk90);
        bus.tx_beat = 0; bus.rx_beat = 0;
      end
    end
    seen = 0;
    for (int w = 0; w < 200; w++) begin
      if (bus.trans_valid === 1'b1) break;
      if (bus.done_valid === 1'b1) begin seen = 1; break; end
      @(negedge clk90);
      cyc++;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_wait got valid=%b done=%b want done=1", bus.trans_valid, bus.done_valid);
      hard_reset();
      return;
    end
    if (ntr == 0) lat = cyc;
    n_checks++;
    if (bus.done_error !== exp_err) begin
      n_fail++;
      $display("FAIL done_error got=%b want=%b", bus.done_error, exp_err);
    end
    dhold = int'($urandom_range(0, 2));
    for (int h = 0; h < dhold; h++) begin
      @(negedge clk90);
      n_checks++;
      if (bus.done_valid !== 1'b1 || bus.done_error !== exp_err) begin
        n_fail++;
        $display("FAIL done_hold got=%b/%b want=1/%b", bus.done_valid, bus.done_error, exp_err);
      end
    end
    bus.done_ready = 1;
    @(negedge clk90);
    bus.done_ready = 0;
    n_checks++;
    if (bus.done_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL done_release got done=%b ready=%b want 0/1", bus.done_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    logic [47:0] got;
    hard_reset();
    got = {bus.trans_address, bus.trans_burst, bus.trans_cs, bus.trans_write,
           bus.trans_address_space};
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.trans_valid !== 1'b0 || bus.done_valid !== 1'b0 ||
        bus.done_error !== 1'b0 || got !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b tv=%b dv=%b de=%b f=%h want 1/0/0/0/0",
               bus.req_ready, bus.trans_valid, bus.done_valid, bus.done_error, got);
    end
  endtask

  task automatic test_single_read();
    int lat;
    do_request(32'h10, 8, 2'b01, 1'b0, 1'b0, -1, 1'b0, 1, lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL issue_latency got=%0d want=3", lat);
    end
  endtask

  task automatic test_boundary_write();
    int lat;
    do_request(32'h3F0, 40, 2'b10, 1'b1, 1'b0, -1, 1'b0, 0, lat);
    do_request(32'hFFFF_FFF8, 20, 2'b01, 1'b0, 1'b0, -1, 1'b0, 2, lat);
  endtask

  task automatic test_max_burst_read();
    int lat;
    do_request(32'h0, 600, 2'b01, 1'b0, 1'b0, -1, 1'b0, 0, lat);
  endtask

  task automatic test_zero_len();
    int lat;
    do_request(32'h1234, 0, 2'b01, 1'b1, 1'b0, -1, 1'b0, 0, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL zero_len_latency got=%0d want=2", lat);
    end
  endtask

  task automatic test_error();
    int lat;
    do_request(32'h0, 300, 2'b01, 1'b1, 1'b0, 10, 1'b0, 0, lat);
    // Error coinciding with the final beat of the first burst still wins.
    do_request(32'h3F0, 40, 2'b10, 1'b0, 1'b0, 15, 1'b1, 1, lat);
  endtask

  task automatic test_register();
    int lat;
    do_request(32'h8, 5, 2'b10, 1'b1, 1'b1, -1, 1'b0, 3, lat);
  endtask

  task automatic test_mid_reset();
    int bad;
    clear_inputs();
    @(negedge clk90);
    bus.req_valid = 1; bus.req_addr = 32'h40; bus.req_len = 20; bus.req_cs = 2'b01;
    @(negedge clk90);
    bus.req_valid = 0;
    repeat (2) @(negedge clk90);
    bus.trans_ready = 1;
    @(negedge clk90);
    bus.trans_ready = 0;
    repeat (3) begin
      bus.rx_beat = 1;
      @(negedge clk90);
      bus.rx_beat = 0;
    end
    rst_ni = 0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.trans_valid !== 1'b0 || bus.done_valid !== 1'b0 ||
        bus.trans_address !== 32'h0 || bus.trans_burst !== '0) begin
      n_fail++;
      $display("FAIL mid_reset got rdy=%b tv=%b dv=%b a=%h b=%h want 1/0/0/0/0", bus.req_ready,
               bus.trans_valid, bus.done_valid, bus.trans_address, bus.trans_burst);
    end
    @(negedge clk90);
    rst_ni = 1;
    bad = 0;
    repeat (10) begin
      @(negedge clk90);
      if (bus.done_valid !== 1'b0 || bus.trans_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL no_done_after_reset got=%0d active cycles want=0", bad);
    end
  endtask

  task automatic test_random();
    int lat, eb;
    logic [31:0] addr;
    int unsigned len;
    logic sp, wr;
    logic [1:0] cs;
    for (int i = 0; i < 14; i++) begin
      addr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 1023));
      len  = $urandom_range(0, 600);
      sp   = ($urandom_range(0, 7) == 0);
      wr   = 1'($urandom_range(0, 1));
      cs   = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      build_model(addr, len, sp);
      eb = -1;
      if (exp_burst.size() > 0 && $urandom_range(0, 4) == 0)
        eb = int'($urandom_range(0, exp_burst[0] - 1));
      do_request(addr, len, cs, wr, sp, eb, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), lat);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_boundary_write();
    test_max_burst_read();
    test_zero_len();
    test_error();
    test_register();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
